// File: rtl/coriolis_ker1_subker1_y_skid_if.sv
// Stream bundle for the delay-buffer receive FIFO: upstream write side, downstream read side, occupancy.
// slave = FIFO view, master = the driving environment's view.
interface coriolis_ker1_subker1_y_skid_if #(
    parameter int STREAMW = 34,
    parameter int DEPTH   = 4
);
    logic                    ivalid;
    logic                    iready;
    logic [STREAMW-1:0]      idata;
    logic                    ovalid;
    logic                    oready;
    logic [STREAMW-1:0]      odata;
    logic [$clog2(DEPTH):0]  count;

    modport slave (
        input  ivalid, idata, oready,
        output iready, ovalid, odata, count
    );

    modport master (
        output ivalid, idata, oready,
        input  iready, ovalid, odata, count
    );
endinterface

// File: rtl/coriolis_ker1_subker1_y_skid.sv
// Elastic receive FIFO for the delay-buffer stream (DEPTH entries, strict order, CORIOLIS_SKID_FWFT_EN adds an empty bypass).
// Latency: 1 cycle write-to-ovalid by default; 0 cycles through the bypass when CORIOLIS_SKID_FWFT_EN is defined.
// Backpressure: iready depends on registered occupancy only, so a full FIFO refuses writes even while it is being read.
module coriolis_ker1_subker1_y_skid #(
    parameter int STREAMW = 34,
    parameter int DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    coriolis_ker1_subker1_y_skid_if.slave      bus
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [STREAMW-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]    count_q, count_d;
    // Holds iready low through reset and for the first edge after release.
    logic               rdy_en_q, rdy_en_d;

    logic               empty;
    logic               iready;
    logic               ovalid;
    logic [STREAMW-1:0] odata;
    logic               store;
    logic               pop;

    always_comb begin
        empty  = (count_q == '0);
        iready = rdy_en_q && (count_q < CNTW'(DEPTH));
`ifdef CORIOLIS_SKID_FWFT_EN
        ovalid = !empty || (rdy_en_q && bus.ivalid);
        odata  = empty ? bus.idata : mem_q[rd_ptr_q];
        // A word offered to an empty FIFO that is taken downstream at once is never stored.
        store  = bus.ivalid && iready && !(empty && bus.oready);
`else
        ovalid = !empty;
        odata  = mem_q[rd_ptr_q];
        store  = bus.ivalid && iready;
`endif
        pop    = !empty && bus.oready;
    end

    always_comb begin
        rdy_en_d = 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({store, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rdy_en_q <= rdy_en_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= bus.idata;
        end
    end

    assign bus.iready = iready;
    assign bus.ovalid = ovalid;
    assign bus.odata  = odata;
    assign bus.count  = count_q;
endmodule
